// File: rtl/wb_result_arbiter_if.sv
// Request bus between the execution-unit result producers and wb_result_arbiter.
// Signal suffixes are from the arbiter's point of view.
interface wb_result_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned SID_W = 4
);
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ*5-1:0]     req_rd_i;
   logic [NREQ*64-1:0]    req_value_i;
   logic [NREQ-1:0]       req_redirect_i;
   logic [NREQ*64-1:0]    req_redirect_pc_i;
   logic [NREQ*SID_W-1:0] req_sid_i;
   logic [NREQ-1:0]       req_ready_o;

   modport master (
      output req_valid_i, req_rd_i, req_value_i, req_redirect_i,
             req_redirect_pc_i, req_sid_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i, req_rd_i, req_value_i, req_redirect_i,
             req_redirect_pc_i, req_sid_i,
      output req_ready_o
   );
endinterface

// File: rtl/wb_result_arbiter.sv
// Age-ordered arbiter sharing two writeback slots among NREQ result producers,
// with a post-redirect kill window. Optional perf counters under WB_ARB_PERF_EN.
module wb_result_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned SID_W       = 4,
   parameter int unsigned KILL_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wb_result_arbiter_if.slave    req_if,
   input  logic                  wb_stall_i,
   input  logic                  flush_i,
   output logic                  slot0_valid_o,
   output logic [4:0]            slot0_rd_o,
   output logic [63:0]           slot0_value_o,
   output logic [SID_W-1:0]      slot0_sid_o,
   output logic                  slot0_redirect_o,
   output logic [63:0]           slot0_redirect_pc_o,
   output logic                  slot1_valid_o,
   output logic [4:0]            slot1_rd_o,
   output logic [63:0]           slot1_value_o,
   output logic [SID_W-1:0]      slot1_sid_o,
   output logic                  slot1_redirect_o,
   output logic [63:0]           slot1_redirect_pc_o,
`ifdef WB_ARB_PERF_EN
   output logic [31:0]           perf_grant_cnt_o,
   output logic [31:0]           perf_conflict_cnt_o,
   output logic [31:0]           perf_kill_cnt_o,
`endif
   output logic                  kill_active_o
);
   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CNT_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

   typedef struct packed {
      logic [4:0]       rd;
      logic [63:0]      value;
      logic [SID_W-1:0] sid;
      logic             redirect;
      logic [63:0]      pc;
   } slot_t;

   typedef enum logic {IDLE, KILL} state_t;

   // a is older than b, accounting for the wrap bit
   function automatic logic older(input logic [SID_W-1:0] a, input logic [SID_W-1:0] b);
      if (a[SID_W-1] == b[SID_W-1]) return a[SID_W-2:0] < b[SID_W-2:0];
      else                          return a[SID_W-2:0] > b[SID_W-2:0];
   endfunction

   slot_t             req_pl [NREQ];
   slot_t             slot0_q, slot1_q;
   logic              slot0_valid_q, slot1_valid_q;
   state_t            state_q, state_d;
   logic [SID_W-1:0]  kill_sid_q, kill_sid_d;
   logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;
   logic [NREQ-1:0]   elig, drop, ready;
   logic              found0, found1, grant0, grant1, advance, load_redir;
   logic [IDX_W-1:0]  idx0, idx1;
   logic [SID_W-1:0]  redir_sid;

   always_comb begin : unpack
      for (int i = 0; i < NREQ; i++) begin
         req_pl[i].rd       = req_if.req_rd_i[i*5 +: 5];
         req_pl[i].value    = req_if.req_value_i[i*64 +: 64];
         req_pl[i].sid      = req_if.req_sid_i[i*SID_W +: SID_W];
         req_pl[i].redirect = req_if.req_redirect_i[i];
         req_pl[i].pc       = req_if.req_redirect_pc_i[i*64 +: 64];
      end
   end

   // Eligibility, two-oldest pick, grants and ready
   always_comb begin : arbitrate
      elig    = '0;
      drop    = '0;
      ready   = '0;
      found0  = 1'b0;
      found1  = 1'b0;
      idx0    = '0;
      idx1    = '0;
      advance = !wb_stall_i || !(slot0_valid_q || slot1_valid_q);
      for (int i = 0; i < NREQ; i++) begin
         drop[i] = req_if.req_valid_i[i] && (state_q == KILL) && older(kill_sid_q, req_pl[i].sid);
         elig[i] = req_if.req_valid_i[i] && !drop[i];
      end
      for (int i = 0; i < NREQ; i++) begin
         if (elig[i] && (!found0 || older(req_pl[i].sid, req_pl[idx0].sid))) begin
            found0 = 1'b1;
            idx0   = IDX_W'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (elig[i] && (idx0 != IDX_W'(i)) &&
             (!found1 || older(req_pl[i].sid, req_pl[idx1].sid))) begin
            found1 = 1'b1;
            idx1   = IDX_W'(i);
         end
      end
      grant0 = advance && !flush_i && found0;
      grant1 = advance && !flush_i && found1 && !req_pl[idx0].redirect;
      for (int i = 0; i < NREQ; i++) begin
         ready[i] = !flush_i && ((grant0 && idx0 == IDX_W'(i)) ||
                                 (grant1 && idx1 == IDX_W'(i)) || drop[i]);
      end
      load_redir = (grant0 && req_pl[idx0].redirect) || (grant1 && req_pl[idx1].redirect);
      redir_sid  = (grant0 && req_pl[idx0].redirect) ? req_pl[idx0].sid : req_pl[idx1].sid;
   end

   assign req_if.req_ready_o = ready;

   // Kill window next-state
   always_comb begin : kill_fsm
      state_d    = state_q;
      kill_sid_d = kill_sid_q;
      kill_cnt_d = kill_cnt_q;
      if (flush_i) begin
         state_d    = IDLE;
         kill_cnt_d = '0;
      end else if (load_redir) begin
         state_d    = KILL;
         kill_sid_d = redir_sid;
         kill_cnt_d = CNT_W'(KILL_CYCLES - 1);
      end else if (state_q == KILL) begin
         if (kill_cnt_q == '0) state_d = IDLE;
         else                  kill_cnt_d = kill_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         kill_sid_q <= '0;
         kill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         kill_sid_q <= kill_sid_d;
         kill_cnt_q <= kill_cnt_d;
      end
   end

   // Slot registers: valids follow grants, payload only on grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_valid_q <= 1'b0;
         slot1_valid_q <= 1'b0;
         slot0_q       <= '0;
         slot1_q       <= '0;
      end else begin
         if (flush_i) begin
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
         end else if (advance) begin
            slot0_valid_q <= grant0;
            slot1_valid_q <= grant1;
         end
         if (grant0) slot0_q <= req_pl[idx0];
         if (grant1) slot1_q <= req_pl[idx1];
      end
   end

   assign slot0_valid_o       = slot0_valid_q;
   assign slot0_rd_o          = slot0_q.rd;
   assign slot0_value_o       = slot0_q.value;
   assign slot0_sid_o         = slot0_q.sid;
   assign slot0_redirect_o    = slot0_q.redirect;
   assign slot0_redirect_pc_o = slot0_q.pc;
   assign slot1_valid_o       = slot1_valid_q;
   assign slot1_rd_o          = slot1_q.rd;
   assign slot1_value_o       = slot1_q.value;
   assign slot1_sid_o         = slot1_q.sid;
   assign slot1_redirect_o    = slot1_q.redirect;
   assign slot1_redirect_pc_o = slot1_q.pc;
   assign kill_active_o       = (state_q == KILL);

`ifdef WB_ARB_PERF_EN
   function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [31:0] inc);
      logic [32:0] s;
      s = {1'b0, c} + {1'b0, inc};
      return s[32] ? '1 : s[31:0];
   endfunction

   logic [31:0] perf_grant_q, perf_conflict_q, perf_kill_q;
   logic [31:0] n_grant, n_elig, n_drop;

   always_comb begin : perf_counts
      n_grant = 32'(grant0) + 32'(grant1);
      n_elig  = '0;
      n_drop  = '0;
      for (int i = 0; i < NREQ; i++) begin
         n_elig = n_elig + 32'(elig[i]);
         n_drop = n_drop + 32'(drop[i] && !flush_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant_q    <= '0;
         perf_conflict_q <= '0;
         perf_kill_q     <= '0;
      end else begin
         perf_grant_q    <= sat_add(perf_grant_q, n_grant);
         perf_conflict_q <= sat_add(perf_conflict_q, 32'(n_elig > 32'd2));
         perf_kill_q     <= sat_add(perf_kill_q, n_drop);
      end
   end

   assign perf_grant_cnt_o    = perf_grant_q;
   assign perf_conflict_cnt_o = perf_conflict_q;
   assign perf_kill_cnt_o     = perf_kill_q;
`endif
endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed self-checking bench for wb_result_arbiter: age ordering, stall,
// kill window, re-arm, flush priority and asynchronous reset.
module tb_wb_result_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, wb_stall, flush;
   logic        s0_v, s1_v, s0_redir, s1_redir, kill;
   logic [4:0]  s0_rd, s1_rd;
   logic [63:0] s0_val, s1_val, s0_pc, s1_pc;
   logic [3:0]  s0_sid, s1_sid;
`ifdef WB_ARB_PERF_EN
   logic [31:0] pg, pc_cnt, pk;
`endif
   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   wb_result_arbiter_if #(.NREQ(4), .SID_W(4)) rif ();

   wb_result_arbiter #(.NREQ(4), .SID_W(4), .KILL_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_if(rif), .wb_stall_i(wb_stall), .flush_i(flush),
      .slot0_valid_o(s0_v), .slot0_rd_o(s0_rd), .slot0_value_o(s0_val), .slot0_sid_o(s0_sid),
      .slot0_redirect_o(s0_redir), .slot0_redirect_pc_o(s0_pc),
      .slot1_valid_o(s1_v), .slot1_rd_o(s1_rd), .slot1_value_o(s1_val), .slot1_sid_o(s1_sid),
      .slot1_redirect_o(s1_redir), .slot1_redirect_pc_o(s1_pc),
`ifdef WB_ARB_PERF_EN
      .perf_grant_cnt_o(pg), .perf_conflict_cnt_o(pc_cnt), .perf_kill_cnt_o(pk),
`endif
      .kill_active_o(kill)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] sid, input logic redir, input logic [63:0] pc);
      rif.req_valid_i[i]             = 1'b1;
      rif.req_sid_i[i*4 +: 4]        = sid;
      rif.req_rd_i[i*5 +: 5]         = 5'(i + 1);
      rif.req_value_i[i*64 +: 64]    = 64'hC0DE_0000 + 64'(i);
      rif.req_redirect_i[i]          = redir;
      rif.req_redirect_pc_i[i*64 +: 64] = pc;
   endtask

   task automatic clr_req(input int i);
      rif.req_valid_i[i]    = 1'b0;
      rif.req_redirect_i[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wb_stall = 1'b0; flush = 1'b0;
      rif.req_valid_i = '0; rif.req_redirect_i = '0; rif.req_sid_i = '0;
      rif.req_rd_i = '0; rif.req_value_i = '0; rif.req_redirect_pc_i = '0;
      repeat (2) tick();
      total++; if (s0_v !== 1'b0) $display("FAIL reset_s0_valid got %b want 0", s0_v); else passed++;
      total++; if (s1_v !== 1'b0) $display("FAIL reset_s1_valid got %b want 0", s1_v); else passed++;
      total++; if (kill !== 1'b0) $display("FAIL reset_kill got %b want 0", kill); else passed++;
      total++; if (rif.req_ready_o !== 4'b0000) $display("FAIL reset_ready got %b want 0000", rif.req_ready_o); else passed++;
      total++; if (s0_sid !== 4'h0 || s0_rd !== 5'd0) $display("FAIL reset_s0_data got sid %h rd %0d want 0 0", s0_sid, s0_rd); else passed++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_oldest_two();
      set_req(0, 4'h5, 1'b0, 64'h0); set_req(1, 4'h3, 1'b0, 64'h0);
      set_req(2, 4'h7, 1'b0, 64'h0); set_req(3, 4'h4, 1'b0, 64'h0);
      #1;
      total++; if (rif.req_ready_o !== 4'b1010) $display("FAIL pick1_ready got %b want 1010", rif.req_ready_o); else passed++;
      tick();
      total++; if (s0_v !== 1'b1 || s0_sid !== 4'h3 || s0_rd !== 5'd2) $display("FAIL pick1_s0 got v%b sid %h rd %0d want v1 sid 3 rd 2", s0_v, s0_sid, s0_rd); else passed++;
      total++; if (s1_v !== 1'b1 || s1_sid !== 4'h4 || s1_rd !== 5'd4) $display("FAIL pick1_s1 got v%b sid %h rd %0d want v1 sid 4 rd 4", s1_v, s1_sid, s1_rd); else passed++;
      total++; if (s0_val !== 64'hC0DE_0001) $display("FAIL pick1_s0_value got %h want c0de0001", s0_val); else passed++;
      clr_req(1); clr_req(3);
      #1;
      total++; if (rif.req_ready_o !== 4'b0101) $display("FAIL pick2_ready got %b want 0101", rif.req_ready_o); else passed++;
      tick();
      total++; if (s0_sid !== 4'h5 || s1_sid !== 4'h7 || !s0_v || !s1_v) $display("FAIL pick2_slots got %h %h want 5 7", s0_sid, s1_sid); else passed++;
      clr_req(0); clr_req(2);
   endtask

   task automatic test_wrap_and_tie();
      set_req(0, 4'h9, 1'b0, 64'h0); set_req(1, 4'h6, 1'b0, 64'h0);
      #1;
      total++; if (rif.req_ready_o !== 4'b0011) $display("FAIL wrap_ready got %b want 0011", rif.req_ready_o); else passed++;
      tick();
      total++; if (s0_sid !== 4'h6 || s0_rd !== 5'd2 || s1_sid !== 4'h9) $display("FAIL wrap_order got s0 %h rd %0d s1 %h want 6 2 9", s0_sid, s0_rd, s1_sid); else passed++;
      clr_req(0); clr_req(1);
      set_req(2, 4'h2, 1'b0, 64'h0); set_req(0, 4'h2, 1'b0, 64'h0);
      tick();
      total++; if (s0_rd !== 5'd1 || s1_rd !== 5'd3) $display("FAIL tie_order got rd %0d %0d want 1 3", s0_rd, s1_rd); else passed++;
      clr_req(0); clr_req(2);
   endtask

   task automatic test_stall();
      set_req(0, 4'h1, 1'b0, 64'h0); set_req(1, 4'h2, 1'b0, 64'h0);
      tick();
      clr_req(0); clr_req(1);
      wb_stall = 1'b1;
      set_req(2, 4'h3, 1'b0, 64'h0); set_req(3, 4'h4, 1'b0, 64'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (rif.req_ready_o !== 4'b0000) $display("FAIL stall_ready%0d got %b want 0000", c, rif.req_ready_o); else passed++;
         tick();
         total++; if (!s0_v || s0_sid !== 4'h1 || !s1_v || s1_sid !== 4'h2) $display("FAIL stall_hold%0d got %h %h want 1 2", c, s0_sid, s1_sid); else passed++;
      end
      wb_stall = 1'b0;
      #1;
      total++; if (rif.req_ready_o !== 4'b1100) $display("FAIL unstall_ready got %b want 1100", rif.req_ready_o); else passed++;
      tick();
      total++; if (s0_sid !== 4'h3 || s1_sid !== 4'h4) $display("FAIL unstall_slots got %h %h want 3 4", s0_sid, s1_sid); else passed++;
      clr_req(2); clr_req(3);
      tick();
      total++; if (s0_v !== 1'b0 || s1_v !== 1'b0) $display("FAIL empty_slots got %b %b want 0 0", s0_v, s1_v); else passed++;
   endtask

   task automatic test_kill_window();
      set_req(2, 4'h2, 1'b1, 64'h8000_0040); set_req(0, 4'h3, 1'b0, 64'h0);
      #1;
      total++; if (rif.req_ready_o !== 4'b0100) $display("FAIL redir_ready got %b want 0100", rif.req_ready_o); else passed++;
      tick();
      total++; if (!s0_v || s0_sid !== 4'h2 || !s0_redir || s0_pc !== 64'h8000_0040) $display("FAIL redir_s0 got v%b sid %h r%b pc %h", s0_v, s0_sid, s0_redir, s0_pc); else passed++;
      total++; if (s1_v !== 1'b0 || kill !== 1'b1) $display("FAIL redir_s1_kill got s1v %b kill %b want 0 1", s1_v, kill); else passed++;
      clr_req(2);
      #1;
      total++; if (rif.req_ready_o !== 4'b0001) $display("FAIL drop_ready got %b want 0001", rif.req_ready_o); else passed++;
      tick();
      total++; if (s0_v !== 1'b0 || s1_v !== 1'b0) $display("FAIL drop_slots got %b %b want 0 0", s0_v, s1_v); else passed++;
      clr_req(0);
      repeat (6) tick();
      total++; if (kill !== 1'b1) $display("FAIL kill_last_cycle got %b want 1", kill); else passed++;
      tick();
      total++; if (kill !== 1'b0) $display("FAIL kill_expire got %b want 0", kill); else passed++;
   endtask

   task automatic test_rearm_and_flush();
      set_req(2, 4'h5, 1'b1, 64'h200);
      tick();
      clr_req(2);
      set_req(1, 4'h1, 1'b1, 64'h100); set_req(3, 4'h6, 1'b0, 64'h0);
      #1;
      total++; if (rif.req_ready_o !== 4'b1010) $display("FAIL rearm_ready got %b want 1010", rif.req_ready_o); else passed++;
      tick();
      total++; if (!s0_v || s0_sid !== 4'h1 || !s0_redir || s1_v) $display("FAIL rearm_slots got v%b sid %h r%b s1v %b", s0_v, s0_sid, s0_redir, s1_v); else passed++;
      clr_req(1); clr_req(3);
      set_req(0, 4'h3, 1'b0, 64'h0);
      #1;
      total++; if (rif.req_ready_o !== 4'b0001) $display("FAIL newsid_drop got %b want 0001", rif.req_ready_o); else passed++;
      tick();
      clr_req(0);
      repeat (5) tick();
      set_req(2, 4'h0, 1'b0, 64'h0);
      #1;
      total++; if (rif.req_ready_o !== 4'b0100) $display("FAIL older_in_kill got %b want 0100", rif.req_ready_o); else passed++;
      tick();
      total++; if (kill !== 1'b1 || !s0_v || s0_sid !== 4'h0) $display("FAIL rearm_window got kill %b s0v %b sid %h want 1 1 0", kill, s0_v, s0_sid); else passed++;
      clr_req(2);
      set_req(3, 4'h0, 1'b0, 64'h0);
      flush = 1'b1;
      #1;
      total++; if (rif.req_ready_o !== 4'b0000) $display("FAIL flush_ready got %b want 0000", rif.req_ready_o); else passed++;
      tick();
      flush = 1'b0;
      total++; if (s0_v !== 1'b0 || s1_v !== 1'b0 || kill !== 1'b0) $display("FAIL flush_clear got %b %b kill %b want 0 0 0", s0_v, s1_v, kill); else passed++;
      tick();
      total++; if (!s0_v || s0_rd !== 5'd4) $display("FAIL post_flush_grant got v%b rd %0d want 1 4", s0_v, s0_rd); else passed++;
      clr_req(3);
      tick();
   endtask

   task automatic test_flush_vs_redirect();
      set_req(1, 4'h4, 1'b1, 64'h300);
      flush = 1'b1;
      #1;
      total++; if (rif.req_ready_o !== 4'b0000) $display("FAIL flushredir_ready got %b want 0000", rif.req_ready_o); else passed++;
      tick();
      flush = 1'b0;
      total++; if (s0_v !== 1'b0 || kill !== 1'b0) $display("FAIL flushredir_state got s0v %b kill %b want 0 0", s0_v, kill); else passed++;
      tick();
      clr_req(1);
      total++; if (kill !== 1'b1 || !s0_redir || s0_pc !== 64'h300) $display("FAIL late_redir got kill %b r%b pc %h", kill, s0_redir, s0_pc); else passed++;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (kill !== 1'b0) $display("FAIL flush_exit_kill got %b want 0", kill); else passed++;
   endtask

   task automatic test_async_reset();
      set_req(0, 4'h5, 1'b1, 64'h400);
      tick();
      clr_req(0);
      total++; if (s0_v !== 1'b1 || kill !== 1'b1) $display("FAIL pre_reset got s0v %b kill %b want 1 1", s0_v, kill); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (s0_v !== 1'b0 || kill !== 1'b0) $display("FAIL async_reset got s0v %b kill %b want 0 0", s0_v, kill); else passed++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_oldest_two();
      test_wrap_and_tie();
      test_stall();
      test_kill_window();
      test_rearm_and_flush();
      test_flush_vs_redirect();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout passed %0d of %0d", passed, total);
      $fatal(1, "timeout");
   end
endmodule
